// File: rtl/regfile_pkg.sv
// Shared definitions for the sweep-initialised multiport register file:
// FSM state encoding, default init values for sp/gp and the per-index
// init value lookup used by the clear engine.
package regfile_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_IDLE  = 1'b1
    } state_t;

    localparam logic [31:0] SP_INIT_DEFAULT = 32'h7FFF_EFFC;
    localparam logic [31:0] GP_INIT_DEFAULT = 32'h1000_8000;

    // Width used to pass init values through the lookup; callers cast down.
    localparam int INIT_W = 64;

    // Register 2 (sp) and register 3 (gp) start non-zero, everything else is 0.
    function automatic logic [INIT_W-1:0] init_value(
        input int unsigned       idx,
        input logic [INIT_W-1:0] sp,
        input logic [INIT_W-1:0] gp
    );
        logic [INIT_W-1:0] v;
        case (idx)
            2:       v = sp;
            3:       v = gp;
            default: v = '0;
        endcase
        return v;
    endfunction

endpackage

// File: rtl/regfile_sweep_multiport_decoder.sv
// Enable-gated binary-to-one-hot decoder. Drives the write select output
// and the per-register write/clear enables of the register file.
module decoder_onehot
    import regfile_pkg::*;
#(
    parameter int ADDR_WIDTH = 5
) (
    input  logic                         en,
    input  logic [ADDR_WIDTH-1:0]        idx,
    output logic [(2**ADDR_WIDTH)-1:0]   onehot
);

    // One bit set at idx when enabled, all-zero otherwise.
    always_comb begin
        onehot      = '0;
        if (en) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

// File: rtl/regfile_sweep_multiport.sv
// Parametrised register file: NUM_READ combinational read ports with
// same-cycle write forwarding, optional hardwired-zero register 0, a
// ready-handshaked write port with one-hot select, and a sequential clear
// engine that rewrites every register (one per cycle) after reset or on
// request.
//
// Write handshake: write_enable_i acts as valid, write_ready_o as ready.
// A write transfers on a cycle where both are high; that transfer is
// visible on write_select_o and via forwarding in the same cycle and is in
// storage from the next edge. write_ready_o never depends on
// write_enable_i, and is low during reset and the whole clear sweep.
module regfile_sweep_multiport
    import regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH = 32,
    parameter int                    ADDR_WIDTH = 5,
    parameter int                    NUM_READ   = 2,
    parameter int                    ZERO_REG   = 1,
    parameter logic [DATA_WIDTH-1:0] SP_INIT    = DATA_WIDTH'(SP_INIT_DEFAULT),
    parameter logic [DATA_WIDTH-1:0] GP_INIT    = DATA_WIDTH'(GP_INIT_DEFAULT)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           write_enable_i,
    input  logic [ADDR_WIDTH-1:0]          write_reg_i,
    input  logic [DATA_WIDTH-1:0]          write_data_i,
    output logic                           write_ready_o,
    output logic [(2**ADDR_WIDTH)-1:0]     write_select_o,
    input  logic                           clear_req_i,
    output logic                           busy_o,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] read_reg_i,
    output logic [NUM_READ*DATA_WIDTH-1:0] read_data_o
);

    localparam int DEPTH = 2**ADDR_WIDTH;

    // Register 0 never takes a write when it is hardwired to zero.
    localparam logic [DEPTH-1:0] ZERO_MASK = (ZERO_REG != 0) ? DEPTH'(1) : '0;

    state_t                  state;
    state_t                  state_next;
    logic [ADDR_WIDTH-1:0]   clr_ptr;
    logic [ADDR_WIDTH-1:0]   clr_ptr_next;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

    logic                    in_idle;
    logic                    clr_en;
    logic                    write_accept;
    logic [DEPTH-1:0]        clr_sel;
    logic [DEPTH-1:0]        wr_en;

    // Reset forces the "not available" face immediately, even before the
    // first edge has put the FSM into CLEAR.
    assign in_idle       = reset && (state == ST_IDLE);
    assign clr_en        = reset && (state == ST_CLEAR);
    assign write_ready_o = in_idle;
    assign busy_o        = !in_idle;
    assign write_accept  = write_enable_i && write_ready_o;

    decoder_onehot #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_write_dec (
        .en     (write_accept),
        .idx    (write_reg_i),
        .onehot (write_select_o)
    );

    decoder_onehot #(
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_clear_dec (
        .en     (clr_en),
        .idx    (clr_ptr),
        .onehot (clr_sel)
    );

    // The select still shows bit 0 for a write to x0; only storage ignores it.
    assign wr_en = write_select_o & ~ZERO_MASK;

    // State register and sweep pointer; reset restarts the sweep at index 0.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_CLEAR;
            clr_ptr <= '0;
        end else begin
            state   <= state_next;
            clr_ptr <= clr_ptr_next;
        end
    end

    // Sweep advances one index per cycle; clear requests only count in IDLE.
    always_comb begin
        state_next   = state;
        clr_ptr_next = clr_ptr;
        case (state)
            ST_CLEAR: begin
                clr_ptr_next = clr_ptr + 1'b1;
                if (&clr_ptr) begin
                    state_next = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (clear_req_i) begin
                    state_next   = ST_CLEAR;
                    clr_ptr_next = '0;
                end
            end
            default: begin
                state_next   = ST_CLEAR;
                clr_ptr_next = '0;
            end
        endcase
    end

    // Storage update: sweep init value or accepted write (never both, since
    // writes are only accepted in IDLE). No reset here on purpose.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            if (clr_sel[i]) begin
                mem[i] <= DATA_WIDTH'(init_value(i, INIT_W'(SP_INIT), INIT_W'(GP_INIT)));
            end else if (wr_en[i]) begin
                mem[i] <= write_data_i;
            end
        end
    end

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] idx;
        logic [DATA_WIDTH-1:0] val;

        assign idx = read_reg_i[k*ADDR_WIDTH +: ADDR_WIDTH];

        // Read priority: unavailable -> 0, x0 -> 0, same-cycle write -> forwarded data, else storage.
        always_comb begin
            val = mem[idx];
            if (write_accept && (write_reg_i == idx)) begin
                val = write_data_i;
            end
            if ((ZERO_REG != 0) && (idx == '0)) begin
                val = '0;
            end
            if (!in_idle) begin
                val = '0;
            end
        end

        assign read_data_o[k*DATA_WIDTH +: DATA_WIDTH] = val;
    end

endmodule
